// File: rtl/div_unit_pkg.sv
// Shared encodings and sizing for the iterative integer divider.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage : div_unit_pkg

// File: rtl/div_restoring_step.sv
// One radix-2 restoring division step: trial-subtract the divisor from the
// partial remainder and keep the difference when it does not go negative.
module div_restoring_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   i_partial,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem_next,
    output logic             o_q_bit
);

    logic [WIDTH-1:0] w_diff;

    // Trial subtraction; a kept difference is always below the divisor, so it fits WIDTH bits.
    always_comb begin
        o_q_bit    = (i_partial >= {1'b0, i_divisor});
        w_diff     = WIDTH'(i_partial - {1'b0, i_divisor});
        o_rem_next = o_q_bit ? w_diff : i_partial[WIDTH-1:0];
    end

endmodule : div_restoring_step

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider for the EX1/EX2 pipeline.
// One operation in flight; holds EX2 via stall_divider, pulses div_ready on completion.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_flush,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_ready,
    output logic             stall_divider,
    output logic             div_busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_e       r_state;
    div_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_div_ready;

    logic             w_accept;
    logic             w_stall;
    logic             w_div_zero;
    logic             w_last_step;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_final;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;

    assign w_div_zero  = (divisor == '0);
    assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_dvd_mag   = (div_signed && dividend[WIDTH-1]) ? WIDTH'(-dividend) : dividend;
    assign w_dvs_mag   = (div_signed && divisor[WIDTH-1])  ? WIDTH'(-divisor)  : divisor;
    assign w_q_final   = {r_dvd[WIDTH-2:0], w_q_bit};

    // Single shared restoring step; the dividend register shifts its MSB into the partial remainder.
    div_restoring_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_partial  ({r_rem, r_dvd[WIDTH-1]}),
        .i_divisor  (r_dvs),
        .o_rem_next (w_rem_next),
        .o_q_bit    (w_q_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, accept and stall decode; flush overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            DIV_IDLE, DIV_DONE: begin
                w_accept = div_start & ~div_flush;
                if (w_accept) begin
                    w_state_next = w_div_zero ? DIV_DONE : DIV_CALC;
                end else begin
                    w_state_next = DIV_IDLE;
                end
            end
            DIV_CALC: begin
                w_stall = 1'b1;
                if (w_last_step) begin
                    w_state_next = DIV_DONE;
                end
            end
            default: w_state_next = DIV_IDLE;
        endcase
        if (w_accept) begin
            w_stall = 1'b1;
        end
        if (div_flush) begin
            w_state_next = DIV_IDLE;
        end
    end

    // Operand latch on accept, then one quotient bit per CALC cycle.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else if (w_accept && !w_div_zero) begin
            r_dvd   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_q_neg <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_r_neg <= div_signed & dividend[WIDTH-1];
        end else if (r_state == DIV_CALC && !div_flush) begin
            r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Result registers with sign fix on the final step; divide-by-zero loads its fixed result directly.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_ready <= 1'b0;
        end else begin
            r_div_ready <= (w_state_next == DIV_DONE);
            if (w_accept && w_div_zero) begin
                r_quotient  <= '1;
                r_remainder <= dividend;
            end else if (r_state == DIV_CALC && w_last_step && !div_flush) begin
                r_quotient  <= r_q_neg ? WIDTH'(-w_q_final)  : w_q_final;
                r_remainder <= r_r_neg ? WIDTH'(-w_rem_next) : w_rem_next;
            end
        end
    end

    assign quotient      = r_quotient;
    assign remainder     = r_remainder;
    assign div_ready     = r_div_ready;
    assign stall_divider = w_stall;
    assign div_busy      = (r_state != DIV_IDLE);

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, scoreboard, and hand-written flush/reset/back-to-back sequences.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_flush;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_ready;
    logic        stall_divider;
    logic        div_busy;

    div_unit dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .div_start     (div_start),
        .div_signed    (div_signed),
        .dividend      (dividend),
        .divisor       (divisor),
        .div_flush     (div_flush),
        .quotient      (quotient),
        .remainder     (remainder),
        .div_ready     (div_ready),
        .stall_divider (stall_divider),
        .div_busy      (div_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[14];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_q   = 32'h0;
    logic [31:0] last_r   = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Drive a request in the current cycle; optionally push its expected result.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eq, input logic [31:0] er);
        exp_t e;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        div_start  = 1'b1;
        #1;
        check32("stall_on_accept", 32'(stall_divider), 32'h1);
        if (push) begin
            e.q = eq;
            e.r = er;
            sb.push_back(e);
        end
        next_cycle();
        div_start = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        #1;
    endtask

    // Wait (bounded) for div_ready; check latency, stall profile and scoreboard result.
    task automatic wait_ready(input int exp_lat, input string name);
        int   lat       = 0;
        int   stall_bad = 0;
        exp_t e;
        for (int k = 1; k <= 60; k++) begin
            if (div_ready === 1'b1) begin
                lat = k;
                break;
            end
            if (k < exp_lat && stall_divider !== 1'b1) stall_bad++;
            next_cycle();
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no div_ready expected one at +%0d", name, exp_lat);
            return;
        end
        check_int({name, "_latency"}, lat, exp_lat);
        check_int({name, "_stall_profile"}, stall_bad, 0);
        check32({name, "_stall_low_in_done"}, 32'(stall_divider), 32'h0);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_ready: got div_ready expected none", name);
            return;
        end
        e = sb.pop_front();
        check32({name, "_quotient"}, quotient, e.q);
        check32({name, "_remainder"}, remainder, e.r);
        last_q = e.q;
        last_r = e.r;
    endtask

    function automatic vec_t mk(input logic s, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] q, input logic [31:0] r, input int lat);
        vec_t v;
        v.sgn = s; v.a = a; v.b = b; v.q = q; v.r = r; v.lat = lat;
        return v;
    endfunction

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic signed [31:0] sa;
        logic signed [31:0] sb_v;
        logic [31:0]        ra;
        logic [31:0]        rb;
        logic [31:0]        mq;
        logic [31:0]        mr;
        logic               rs;
        int                 bad_ready;

        tbl[0]  = mk(1'b0, 32'd100,       32'd7,          32'd14,         32'd2,          33);
        tbl[1]  = mk(1'b1, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33);
        tbl[2]  = mk(1'b0, 32'hFFFFFFF9,  32'd2,          32'h7FFFFFFC,   32'd1,          33);
        tbl[3]  = mk(1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'h0,          33);
        tbl[4]  = mk(1'b1, 32'h12345678,  32'h0,          32'hFFFFFFFF,   32'h12345678,   1);
        tbl[5]  = mk(1'b1, 32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33);
        tbl[6]  = mk(1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   33);
        tbl[7]  = mk(1'b0, 32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,   32'h0,          33);
        tbl[8]  = mk(1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,   32'd1,          32'h0,          33);
        tbl[9]  = mk(1'b0, 32'd5,         32'd10,         32'd0,          32'd5,          33);
        tbl[10] = mk(1'b0, 32'hDEADBEEF,  32'h0,          32'hFFFFFFFF,   32'hDEADBEEF,   1);
        tbl[11] = mk(1'b1, 32'h80000000,  32'd3,          32'hD5555556,   32'hFFFFFFFE,   33);
        tbl[12] = mk(1'b0, 32'h80000000,  32'hFFFFFFFF,   32'h0,          32'h80000000,   33);
        tbl[13] = mk(1'b0, 32'h0,         32'd5,          32'h0,          32'h0,          33);

        aresetn    = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_flush  = 1'b0;
        dividend   = 32'h0;
        divisor    = 32'h0;
        next_cycle();
        next_cycle();
        check32("reset_quotient",  quotient,  32'h0);
        check32("reset_remainder", remainder, 32'h0);
        check32("reset_ready", 32'(div_ready),     32'h0);
        check32("reset_busy",  32'(div_busy),      32'h0);
        check32("reset_stall", 32'(stall_divider), 32'h0);
        aresetn = 1'b1;
        next_cycle();

        // Table-driven vectors, each followed by a hold check one cycle after the pulse.
        for (int i = 0; i < 14; i++) begin
            next_cycle();
            issue(tbl[i].sgn, tbl[i].a, tbl[i].b, 1'b1, tbl[i].q, tbl[i].r);
            wait_ready(tbl[i].lat, $sformatf("vec%0d", i));
            next_cycle();
            check32($sformatf("vec%0d_ready_single_pulse", i), 32'(div_ready), 32'h0);
            check32($sformatf("vec%0d_hold_quotient", i), quotient, last_q);
        end

        // Random vectors against a behavioural model.
        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'h0) rb = 32'd3;
            if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
            if (rs) begin
                sa   = ra;
                sb_v = rb;
                mq   = sa / sb_v;
                mr   = sa % sb_v;
            end else begin
                mq = ra / rb;
                mr = ra % rb;
            end
            next_cycle();
            issue(rs, ra, rb, 1'b1, mq, mr);
            wait_ready(33, $sformatf("rand%0d", i));
        end

        // Back-to-back: new requests accepted in the DONE cycle.
        next_cycle();
        issue(1'b0, 32'd1000, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd1000);
        wait_ready(1, "b2b_zero_a");
        issue(1'b0, 32'd2000, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd2000);
        wait_ready(1, "b2b_zero_b");
        issue(1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0);
        wait_ready(33, "b2b_normal");
        issue(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE);
        wait_ready(33, "b2b_normal2");

        // Flush at T+10 kills the operation; a new 9/3 at T+12 completes at T+45.
        next_cycle();
        issue(1'b0, 32'd1000, 32'd3, 1'b0, 32'h0, 32'h0);
        bad_ready = 0;
        for (int k = 0; k < 9; k++) begin
            if (div_ready !== 1'b0) bad_ready++;
            next_cycle();
        end
        div_flush = 1'b1;
        #1;
        next_cycle();
        div_flush = 1'b0;
        #1;
        if (div_ready !== 1'b0) bad_ready++;
        check_int("flush_no_ready", bad_ready, 0);
        check32("flush_idle_busy", 32'(div_busy), 32'h0);
        check32("flush_result_untouched", quotient, last_q);
        next_cycle();
        issue(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0);
        wait_ready(33, "after_flush");

        // Flush in IDLE beats a simultaneous start.
        next_cycle();
        div_signed = 1'b0;
        dividend   = 32'd8;
        divisor    = 32'd0;
        div_start  = 1'b1;
        div_flush  = 1'b1;
        #1;
        check32("flush_vs_start_stall", 32'(stall_divider), 32'h0);
        next_cycle();
        div_start = 1'b0;
        div_flush = 1'b0;
        #1;
        check32("flush_vs_start_busy",  32'(div_busy),  32'h0);
        check32("flush_vs_start_ready", 32'(div_ready), 32'h0);
        check32("flush_vs_start_q", quotient, last_q);

        // Reset asserted at T+5 of an active divide clears everything at once.
        next_cycle();
        issue(1'b0, 32'd50000, 32'd7, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) next_cycle();
        aresetn = 1'b0;
        #1;
        check32("midreset_quotient",  quotient,  32'h0);
        check32("midreset_remainder", remainder, 32'h0);
        check32("midreset_ready", 32'(div_ready),     32'h0);
        check32("midreset_busy",  32'(div_busy),      32'h0);
        check32("midreset_stall", 32'(stall_divider), 32'h0);
        next_cycle();
        aresetn = 1'b1;
        next_cycle();
        issue(1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0);
        wait_ready(33, "after_reset");

        check_int("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_div_unit
